// File: rtl/midi_voice_scheduler.sv
// MIDI Note On/Off parser and voice allocator: retrigger, lowest free slot, else round-robin steal.
// Optional feature: define MIDI_RUNNING_STATUS_EN to honour MIDI running status.
module midi_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int CHANNEL    = 0
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic                    byte_ready,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_vel,
   output logic                    evt_on,
   output logic                    evt_off,
   output logic [2:0]              evt_voice
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [2:0] {WAIT_STATUS, WAIT_NOTE, WAIT_VEL, IGNORE, ALLOC} state_t;

   state_t                  state_q;
   logic                    msg_on_q;
   logic [6:0]              note_q;
   logic [6:0]              vel_q;
`ifdef MIDI_RUNNING_STATUS_EN
   logic                    rs_valid_q;
`endif
   logic [NUM_VOICES-1:0]   gate_q;
   logic [6:0]              vnote_q [NUM_VOICES];
   logic [6:0]              vvel_q  [NUM_VOICES];
   logic [IDX_W-1:0]        steal_q;
   logic                    ready_q;
   logic                    evt_on_q;
   logic                    evt_off_q;
   logic [2:0]              evt_voice_q;

   logic                    hit;
   logic                    free;
   logic [IDX_W-1:0]        hit_idx;
   logic [IDX_W-1:0]        free_idx;
   logic [IDX_W-1:0]        target;
   logic [IDX_W-1:0]        steal_next;
   logic                    is_on;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      // NOTE: blocking assignments here let the !hit / !free guards see earlier iterations, giving lowest-index priority.
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!hit && gate_q[i] && (vnote_q[i] == note_q)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!free && !gate_q[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
      is_on      = msg_on_q && (vel_q != 7'd0);
      target     = hit ? hit_idx : (free ? free_idx : steal_q);
      steal_next = (steal_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_q + 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= WAIT_STATUS;
         msg_on_q    <= 1'b0;
         note_q      <= '0;
         vel_q       <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
         rs_valid_q  <= 1'b0;
`endif
         gate_q      <= '0;
         steal_q     <= '0;
         ready_q     <= 1'b1;
         evt_on_q    <= 1'b0;
         evt_off_q   <= 1'b0;
         evt_voice_q <= '0;
         // NOTE: the voice arrays drive outputs that must read 0 after reset, so they are reset too.
         for (int i = 0; i < NUM_VOICES; i++) begin
            vnote_q[i] <= '0;
            vvel_q[i]  <= '0;
         end
      end else begin
         evt_on_q  <= 1'b0;
         evt_off_q <= 1'b0;
         if (state_q == ALLOC) begin
            if (is_on) begin
               gate_q[target]  <= 1'b1;
               vnote_q[target] <= note_q;
               vvel_q[target]  <= vel_q;
               evt_on_q        <= 1'b1;
               evt_voice_q     <= 3'(target);
               if (!hit && !free)
                  steal_q <= steal_next;
            end else if (hit) begin
               gate_q[hit_idx] <= 1'b0;
               evt_off_q       <= 1'b1;
               evt_voice_q     <= 3'(hit_idx);
            end
            ready_q <= 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
            state_q <= rs_valid_q ? WAIT_NOTE : WAIT_STATUS;
`else
            state_q <= WAIT_STATUS;
`endif
         end else if (byte_valid) begin
            if (byte_in >= 8'hF8) begin
               // Real-time bytes are consumed without touching parser state.
            end else if (byte_in >= 8'hF0) begin
`ifdef MIDI_RUNNING_STATUS_EN
               rs_valid_q <= 1'b0;
`endif
               state_q <= WAIT_STATUS;
            end else if (byte_in[7]) begin
               if ((byte_in[7:5] == 3'b100) && (byte_in[3:0] == 4'(CHANNEL))) begin
                  msg_on_q <= byte_in[4];
`ifdef MIDI_RUNNING_STATUS_EN
                  rs_valid_q <= 1'b1;
`endif
                  state_q <= WAIT_NOTE;
               end else begin
`ifdef MIDI_RUNNING_STATUS_EN
                  rs_valid_q <= 1'b0;
`endif
                  state_q <= IGNORE;
               end
            end else begin
               case (state_q)
                  WAIT_NOTE: begin
                     note_q  <= byte_in[6:0];
                     state_q <= WAIT_VEL;
                  end
                  WAIT_VEL: begin
                     vel_q   <= byte_in[6:0];
                     state_q <= ALLOC;
                     ready_q <= 1'b0;
                  end
`ifdef MIDI_RUNNING_STATUS_EN
                  WAIT_STATUS: begin
                     if (rs_valid_q) begin
                        note_q  <= byte_in[6:0];
                        state_q <= WAIT_VEL;
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      voice_note = '0;
      voice_vel  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_note[7*i +: 7] = vnote_q[i];
         voice_vel[7*i +: 7]  = vvel_q[i];
      end
   end

   assign byte_ready = ready_q;
   assign voice_gate = gate_q;
   assign evt_on     = evt_on_q;
   assign evt_off    = evt_off_q;
   assign evt_voice  = evt_voice_q;

endmodule

// File: tb/tb_midi_voice_scheduler.sv
// Bench for midi_voice_scheduler: directed vector table, hand sequences, and random bytes vs a message-level model.
module tb_midi_voice_scheduler;

   localparam int NV = 4;
`ifdef MIDI_RUNNING_STATUS_EN
   localparam bit RS = 1'b1;
`else
   localparam bit RS = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic [7:0]      byte_in;
   logic            byte_valid;
   logic            byte_ready;
   logic [NV-1:0]   voice_gate;
   logic [7*NV-1:0] voice_note;
   logic [7*NV-1:0] voice_vel;
   logic            evt_on;
   logic            evt_off;
   logic [2:0]      evt_voice;

   midi_voice_scheduler #(.NUM_VOICES(NV), .CHANNEL(0)) dut (
      .Clock      (clk),
      .Reset_n    (rst_n),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .voice_gate (voice_gate),
      .voice_note (voice_note),
      .voice_vel  (voice_vel),
      .evt_on     (evt_on),
      .evt_off    (evt_off),
      .evt_voice  (evt_voice)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Inputs change on the falling edge; the task returns on the falling edge after the transfer.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!byte_ready) begin
         check("ready_timeout", byte_ready, 1);
         byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Message-level reference: a running note status (or -1) plus collected data bytes.
   bit m_gate [NV];
   int m_note [NV];
   int m_vel  [NV];
   int m_ptr, m_run, m_last;
   bit m_on, m_off;
   int m_data [$];

   function automatic void model_reset();
      for (int i = 0; i < NV; i++) begin
         m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0;
      end
      m_ptr = 0; m_run = -1; m_last = 0; m_on = 0; m_off = 0;
      m_data.delete();
   endfunction

   function automatic void model_event(int n, int v);
      int t = -1;
      if ((m_run & 'h10) != 0 && v != 0) begin
         for (int i = 0; i < NV && t < 0; i++) if (m_gate[i] && m_note[i] == n) t = i;
         for (int i = 0; i < NV && t < 0; i++) if (!m_gate[i]) t = i;
         if (t < 0) begin
            t = m_ptr;
            m_ptr = (m_ptr + 1) % NV;
         end
         m_gate[t] = 1; m_note[t] = n; m_vel[t] = v;
         m_on = 1; m_last = t;
      end else begin
         for (int i = 0; i < NV && t < 0; i++) if (m_gate[i] && m_note[i] == n) t = i;
         if (t >= 0) begin
            m_gate[t] = 0; m_off = 1; m_last = t;
         end
      end
   endfunction

   function automatic void model_byte(int b);
      m_on = 0; m_off = 0;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin
         m_run = -1; m_data.delete();
      end else if (b >= 'h80) begin
         m_run = ((b & 'hE0) == 'h80 && (b & 'h0F) == 0) ? b : -1;
         m_data.delete();
      end else if (m_run >= 0) begin
         m_data.push_back(b);
         if (m_data.size() == 2) begin
            model_event(m_data[0], m_data[1]);
            m_data.delete();
            if (!RS) m_run = -1;
         end
      end
   endfunction

   function automatic logic [7:0] rand_byte();
      int r = $urandom_range(0, 99);
      if (r < 15) return 8'h90;
      if (r < 22) return 8'h80;
      if (r < 26) return 8'(8'h80 | ($urandom_range(0, 1) << 4) | $urandom_range(1, 15));
      if (r < 30) return 8'(8'hA0 + $urandom_range(0, 8'h4F));
      if (r < 33) return 8'(8'hF0 + $urandom_range(0, 7));
      if (r < 40) return 8'(8'hF8 + $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) return 8'h00;
      return 8'(60 + $urandom_range(0, 9));
   endfunction

   typedef struct {
      logic [7:0] b;
      logic       on;
      logic       off;
      logic [2:0] voice;
      logic [3:0] gate;
      logic [6:0] note0;
      logic [6:0] vel0;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input int b, input int on, input int off, input int v, input int g,
                      input int n0, input int v0);
      vec_t e;
      e.b = 8'(b); e.on = 1'(on); e.off = 1'(off); e.voice = 3'(v);
      e.gate = 4'(g); e.note0 = 7'(n0); e.vel0 = 7'(v0);
      tbl.push_back(e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7*NV-1:0] en, ev;
      logic [NV-1:0]   eg;
      rst_n      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;

      // basic note-on, retrigger, release
      add('h90,0,0,0,'h0,'h00,'h00); add('h3C,0,0,0,'h0,'h00,'h00); add('h64,1,0,0,'h1,'h3C,'h64);
      add('h90,0,0,0,'h1,'h3C,'h64); add('h3C,0,0,0,'h1,'h3C,'h64); add('h20,1,0,0,'h1,'h3C,'h20);
      add('h80,0,0,0,'h1,'h3C,'h20); add('h3C,0,0,0,'h1,'h3C,'h20); add('h00,0,1,0,'h0,'h3C,'h20);
      // fill all voices, then steal voice0 and voice1
      add('h90,0,0,0,'h0,'h3C,'h20); add('h3C,0,0,0,'h0,'h3C,'h20); add('h64,1,0,0,'h1,'h3C,'h64);
      add('h90,0,0,0,'h1,'h3C,'h64); add('h3D,0,0,0,'h1,'h3C,'h64); add('h64,1,0,1,'h3,'h3C,'h64);
      add('h90,0,0,1,'h3,'h3C,'h64); add('h3E,0,0,1,'h3,'h3C,'h64); add('h64,1,0,2,'h7,'h3C,'h64);
      add('h90,0,0,2,'h7,'h3C,'h64); add('h3F,0,0,2,'h7,'h3C,'h64); add('h64,1,0,3,'hF,'h3C,'h64);
      add('h90,0,0,3,'hF,'h3C,'h64); add('h40,0,0,3,'hF,'h3C,'h64); add('h64,1,0,0,'hF,'h40,'h64);
      add('h90,0,0,0,'hF,'h40,'h64); add('h41,0,0,0,'hF,'h40,'h64); add('h64,1,0,1,'hF,'h40,'h64);
      // other channel filtered; real-time interleaved
      add('h91,0,0,1,'hF,'h40,'h64); add('h30,0,0,1,'hF,'h40,'h64); add('h40,0,0,1,'hF,'h40,'h64);
      add('h90,0,0,1,'hF,'h40,'h64); add('hF8,0,0,1,'hF,'h40,'h64); add('h30,0,0,1,'hF,'h40,'h64);
      add('hFE,0,0,1,'hF,'h40,'h64); add('h40,1,0,2,'hF,'h40,'h64);
      // trailing data pair: unmatched off (running status) or discarded (no running status)
      add('h90,0,0,2,'hF,'h40,'h64); add('h42,0,0,2,'hF,'h40,'h64); add('h50,1,0,3,'hF,'h40,'h64);
      add('h55,0,0,3,'hF,'h40,'h64); add('h00,0,0,3,'hF,'h40,'h64);
      add('h80,0,0,3,'hF,'h40,'h64); add('h40,0,0,3,'hF,'h40,'h64); add('h00,0,1,0,'hE,'h40,'h64);

      // reset values
      #12;
      check("rst_ready", byte_ready, 1);
      check("rst_gate", voice_gate, 0);
      check("rst_note", voice_note, 0);
      check("rst_vel", voice_vel, 0);
      check("rst_evt_on", evt_on, 0);
      check("rst_evt_off", evt_off, 0);
      check("rst_evt_voice", evt_voice, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // vector table
      foreach (tbl[i]) begin
         send_byte(tbl[i].b);
         @(negedge clk);
         check($sformatf("tbl%0d_on", i), evt_on, tbl[i].on);
         check($sformatf("tbl%0d_off", i), evt_off, tbl[i].off);
         check($sformatf("tbl%0d_voice", i), evt_voice, tbl[i].voice);
         check($sformatf("tbl%0d_gate", i), voice_gate, tbl[i].gate);
         check($sformatf("tbl%0d_note0", i), voice_note[6:0], tbl[i].note0);
         check($sformatf("tbl%0d_vel0", i), voice_vel[6:0], tbl[i].vel0);
      end
      check("tbl_all_notes", voice_note, {7'h42, 7'h30, 7'h41, 7'h40});
      check("tbl_all_vels", voice_vel, {7'h50, 7'h40, 7'h64, 7'h64});

      // ready low in ALLOC, strobe exactly one cycle, byte held through ALLOC is accepted afterwards
      do_reset();
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'h64);
      check("alloc_ready_low", byte_ready, 0);
      check("alloc_no_strobe_yet", evt_on, 0);
      byte_in    = 8'h90;
      byte_valid = 1'b1;
      @(negedge clk);
      check("strobe_on", evt_on, 1);
      check("strobe_ready_back", byte_ready, 1);
      @(negedge clk);
      byte_valid = 1'b0;
      check("strobe_one_cycle", evt_on, 0);
      send_byte(8'h3D);
      send_byte(8'h50);
      @(negedge clk);
      check("held_byte_on", evt_on, 1);
      check("held_byte_voice", evt_voice, 1);
      check("held_byte_gate", voice_gate, 4'b0011);

      // reset mid-message drops the partial message
      do_reset();
      send_byte(8'h90);
      send_byte(8'h3C);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", byte_ready, 1);
      check("midrst_gate", voice_gate, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_ready_after", byte_ready, 1);
      send_byte(8'h64);
      @(negedge clk);
      check("midrst_no_evt", evt_on, 0);
      check("midrst_gate_after", voice_gate, 0);

      // random bytes vs model
      do_reset();
      model_reset();
      for (int k = 0; k < 300; k++) begin
         logic [7:0] b;
         b = rand_byte();
         send_byte(b);
         model_byte(int'(b));
         @(negedge clk);
         eg = '0; en = '0; ev = '0;
         for (int i = 0; i < NV; i++) begin
            eg[i]        = m_gate[i];
            en[7*i +: 7] = 7'(m_note[i]);
            ev[7*i +: 7] = 7'(m_vel[i]);
         end
         check($sformatf("rnd%0d_b%0h_on", k, b), evt_on, m_on);
         check($sformatf("rnd%0d_b%0h_off", k, b), evt_off, m_off);
         check($sformatf("rnd%0d_b%0h_voice", k, b), evt_voice, m_last);
         check($sformatf("rnd%0d_b%0h_gate", k, b), voice_gate, eg);
         check($sformatf("rnd%0d_b%0h_note", k, b), voice_note, en);
         check($sformatf("rnd%0d_b%0h_vel", k, b), voice_vel, ev);
         check($sformatf("rnd%0d_b%0h_ready", k, b), byte_ready, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
